// File: rtl/mux_nlane_serial_pkg.sv
// mux_pkg: shared constants and helpers for the N-lane serialising mux.
//   clog2       - constant-evaluable ceil(log2(v)), v >= 1
//   DEF_WIDTH   - default data word width
//   DEF_LANES   - default lane count (also frame length in clk8f cycles)
//   LANE_IDX_W  - lane index width for the default lane count
package mux_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_LANES  = 4;
  localparam int LANE_IDX_W = clog2(DEF_LANES);

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

endpackage

// File: rtl/mux_nlane_serial_if.sv
// Bus bundle for mux_nlane_serial.
//   master: drives data_in/valid_in/lane_en/pack, observes the serial side
//   slave : the mux; drives data_out/valid_out/lane_idx/frame_strobe/clk_div
interface mux_nlane_serial_if
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES
);
  localparam int LW = clog2(LANES);

  logic [LANES*WIDTH-1:0] data_in;
  logic [LANES-1:0]       valid_in;
  logic [LANES-1:0]       lane_en;
  logic                   pack;
  logic [WIDTH-1:0]       data_out;
  logic                   valid_out;
  logic [LW-1:0]          lane_idx;
  logic                   frame_strobe;
  logic                   clk_div;

  modport master (
    output data_in, valid_in, lane_en, pack,
    input  data_out, valid_out, lane_idx, frame_strobe, clk_div
  );

  modport slave (
    input  data_in, valid_in, lane_en, pack,
    output data_out, valid_out, lane_idx, frame_strobe, clk_div
  );

endinterface

// File: rtl/mux_nlane_serial_lane_pick.sv
// lane_pick: combinational priority encoder.
//   mask  - candidate lanes
//   start - lowest lane index eligible
//   found - some lane at or above start is set in mask
//   idx   - lowest such lane (0 when not found)
module lane_pick
  import mux_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  localparam int LW   = clog2(LANES)
) (
  input  logic [LANES-1:0] mask,
  input  logic [LW-1:0]    start,
  output logic             found,
  output logic [LW-1:0]    idx
);

  // Scan downward so the last hit, i.e. the lowest index, wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i] && (LW'(i) >= start)) begin
        found = 1'b1;
        idx   = LW'(i);
      end
    end
  end

endmodule

// File: rtl/mux_nlane_serial.sv
// mux_nlane_serial: LANES-to-1 interleaving mux on a single clk8f domain.
//   clk8f - fast clock, rising edge
//   reset - asynchronous, active-high
//   bus   - slave side of mux_nlane_serial_if:
//           data_in/valid_in/lane_en/pack sampled once per frame (capture edge),
//           data_out/valid_out/lane_idx one registered slot per cycle,
//           frame_strobe marks the cycle ending in the capture edge,
//           clk_div is the slot counter MSB (period LANES, 50 % duty).
// Fixed mode puts lane k in slot k; pack mode emits valid lanes in order,
// back to back, then idles the rest of the frame.
module mux_nlane_serial
  import mux_pkg::*;
#(
  parameter int             WIDTH     = DEF_WIDTH,
  parameter int             LANES     = DEF_LANES,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input logic               clk8f,
  input logic               reset,
  mux_nlane_serial_if.slave bus
);

  localparam int LW = clog2(LANES);

  logic [LW-1:0]                cnt;
  logic [LANES-1:0][WIDTH-1:0]  shadow_data;
  logic [LANES-1:0]             shadow_valid;
  logic                         frame_pack;
  logic [LANES-1:0]             work_mask;
  logic [LW-1:0]                ptr;
  logic [WIDTH-1:0]             data_out_q;
  logic                         valid_out_q;
  logic [LW-1:0]                lane_idx_q;
  logic                         strobe;
  logic                         pick_found;
  logic [LW-1:0]                pick_idx;

  assign strobe = (cnt == LW'(LANES - 1));

  lane_pick #(.LANES(LANES)) u_pick (
    .mask  (work_mask),
    .start (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Slot k of the current frame is emitted on the edge where cnt == k. The
  // capture edge (cnt == LANES-1) both emits the last slot from the old
  // shadow and loads the new one; non-blocking updates keep them apart.
  always_ff @(posedge clk8f or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      shadow_data  <= '0;
      shadow_valid <= '0;
      frame_pack   <= 1'b0;
      work_mask    <= '0;
      ptr          <= '0;
      data_out_q   <= IDLE_WORD;
      valid_out_q  <= 1'b0;
      lane_idx_q   <= '0;
    end else begin
      cnt <= cnt + 1'b1;

      if (frame_pack) begin
        if (pick_found) begin
          data_out_q          <= shadow_data[pick_idx];
          valid_out_q         <= 1'b1;
          lane_idx_q          <= pick_idx;
          work_mask[pick_idx] <= 1'b0;
          ptr                 <= pick_idx + 1'b1;
        end else begin
          data_out_q  <= IDLE_WORD;
          valid_out_q <= 1'b0;
          lane_idx_q  <= '0;
        end
      end else begin
        data_out_q  <= shadow_valid[cnt] ? shadow_data[cnt] : IDLE_WORD;
        valid_out_q <= shadow_valid[cnt];
        lane_idx_q  <= cnt;
      end

      // Capture last so it overrides the pack-mode mask/pointer update.
      if (strobe) begin
        shadow_data  <= bus.data_in;
        shadow_valid <= bus.valid_in & bus.lane_en;
        frame_pack   <= bus.pack;
        work_mask    <= bus.valid_in & bus.lane_en;
        ptr          <= '0;
      end
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_out_q;
  assign bus.lane_idx     = lane_idx_q;
  assign bus.frame_strobe = strobe;
  assign bus.clk_div      = cnt[LW-1];

endmodule
